// File: rtl/round_controller.sv
// -----------------------------------------------------------------------------
// round_controller
//
// Game sequencer for the switch game. It runs the round cycle
// (break countdown -> new prompt -> play countdown -> pass/fail) and owns the
// countdown value, the count of passed rounds and the score.
//
// Scoring: a passed round is worth 2 << min(rounds_passed_before / DOUBLE_EVERY, 7)
// points. The score saturates at all-ones and the round counter at 255.
//
// Parameters:
//   ROUND_TIME   - play-phase countdown start value in seconds (1..63)
//   BREAK_TIME   - break-phase countdown start value in seconds (1..63)
//   DOUBLE_EVERY - passed rounds per doubling of points-per-round
//   SCORE_W      - score width in bits
//
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   start        in   one-cycle pulse, begins a game (honoured in IDLE/GAMEOVER)
//   tick_1hz     in   one-cycle pulse once per second, synchronous to clk
//   check_valid  in   one-cycle pulse, checker has evaluated a switch change
//   is_correct   in   checker verdict, qualified by check_valid
//   new_prompt   out  one-cycle pulse on the BREAK->PLAY transition
//   count        out  current countdown value for the hex display
//   phase        out  0=IDLE, 1=BREAK, 2=PLAY, 3=GAMEOVER
//   round_num    out  rounds passed in the current game
//   score        out  current game score
//   game_over    out  high while phase==GAMEOVER
//   best_score   out  highest score across games (optional, see below)
//
// Optional feature: define ROUND_CONTROLLER_HIGH_SCORE_EN to add best_score,
// which is updated on the edge that enters GAMEOVER and is cleared only by
// reset_n. Without the macro the port and register do not exist.
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module round_controller #(
    parameter int ROUND_TIME   = 15,
    parameter int BREAK_TIME   = 5,
    parameter int DOUBLE_EVERY = 5,
    parameter int SCORE_W      = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               tick_1hz,
    input  logic               check_valid,
    input  logic               is_correct,
    output logic               new_prompt,
    output logic [5:0]         count,
    output logic [1:0]         phase,
    output logic [7:0]         round_num,
    output logic [SCORE_W-1:0] score,
    output logic               game_over
`ifdef ROUND_CONTROLLER_HIGH_SCORE_EN
    ,
    output logic [SCORE_W-1:0] best_score
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BREAK    = 2'd1,
        ST_PLAY     = 2'd2,
        ST_GAMEOVER = 2'd3
    } state_e;

    localparam logic [5:0] BREAK_CNT = 6'(BREAK_TIME);
    localparam logic [5:0] ROUND_CNT = 6'(ROUND_TIME);

    // A divisor of zero would be meaningless; anything above 255 can never be
    // reached by the 8-bit round counter, so clamping to 256 keeps the tier 0.
    localparam int         DE_SAFE = (DOUBLE_EVERY < 1) ? 1 : DOUBLE_EVERY;
    localparam logic [8:0] DE_DIV  = (DE_SAFE > 256) ? 9'd256 : 9'(DE_SAFE);

    // Score arithmetic is done 10 bits wider than the score so that the
    // largest point value (256) can never wrap before saturation.
    localparam int                 SUM_W     = SCORE_W + 10;
    localparam logic [SUM_W-1:0]   SCORE_MAX = SUM_W'({SCORE_W{1'b1}});

    state_e               state_q, state_d;
    logic [5:0]           count_q, count_d;
    logic [7:0]           round_q, round_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 new_prompt_q, new_prompt_d;
    logic                 game_over_q, game_over_d;

    // ---------------------------------------------------------------------
    // Points for the round being passed, and the saturated results
    // ---------------------------------------------------------------------
    logic [8:0]           tier_raw;
    logic [2:0]           tier;
    logic [8:0]           pts;
    logic [SUM_W-1:0]     score_sum;
    logic [SCORE_W-1:0]   score_sat;
    logic [7:0]           round_inc;

    always_comb begin
        tier_raw  = {1'b0, round_q} / DE_DIV;
        tier      = (tier_raw > 9'd7) ? 3'd7 : tier_raw[2:0];
        pts       = 9'd2 << tier;
        score_sum = SUM_W'(score_q) + SUM_W'(pts);
        score_sat = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
        round_inc = (round_q == 8'hFF) ? 8'hFF : round_q + 8'd1;
    end

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            count_q      <= 6'd0;
            round_q      <= 8'd0;
            score_q      <= '0;
            new_prompt_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            round_q      <= round_d;
            score_q      <= score_d;
            new_prompt_q <= new_prompt_d;
            game_over_q  <= game_over_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and datapath logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        round_d = round_q;
        score_d = score_q;

        unique case (state_q)
            ST_IDLE, ST_GAMEOVER: begin
                if (start) begin
                    state_d = ST_BREAK;
                    count_d = BREAK_CNT;
                    round_d = 8'd0;
                    score_d = '0;
                end
            end

            ST_BREAK: begin
                // check_valid is deliberately ignored here.
                if (tick_1hz) begin
                    if (count_q > 6'd1) begin
                        count_d = count_q - 6'd1;
                    end else begin
                        state_d = ST_PLAY;
                        count_d = ROUND_CNT;
                    end
                end
            end

            ST_PLAY: begin
                // A verdict takes priority over a simultaneous tick, so a
                // correct answer on the last second still passes the round.
                if (check_valid) begin
                    if (is_correct) begin
                        state_d = ST_BREAK;
                        count_d = BREAK_CNT;
                        round_d = round_inc;
                        score_d = score_sat;
                    end else begin
                        state_d = ST_GAMEOVER;
                    end
                end else if (tick_1hz) begin
                    if (count_q > 6'd1) begin
                        count_d = count_q - 6'd1;
                    end else begin
                        state_d = ST_GAMEOVER;
                        count_d = 6'd0;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Registered-output decode
    // ---------------------------------------------------------------------
    always_comb begin
        new_prompt_d = (state_q == ST_BREAK) && (state_d == ST_PLAY);
        game_over_d  = (state_d == ST_GAMEOVER);
    end

    assign new_prompt = new_prompt_q;
    assign count      = count_q;
    assign phase      = state_q;
    assign round_num  = round_q;
    assign score      = score_q;
    assign game_over  = game_over_q;

`ifdef ROUND_CONTROLLER_HIGH_SCORE_EN
    logic [SCORE_W-1:0] best_q, best_d;

    // The score does not change on the edge that enters GAMEOVER, so the
    // current score is the final score of the game.
    always_comb begin
        best_d = best_q;
        if ((state_q == ST_PLAY) && (state_d == ST_GAMEOVER) && (score_q > best_q)) begin
            best_d = score_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            best_q <= '0;
        end else begin
            best_q <= best_d;
        end
    end

    assign best_score = best_q;
`endif

endmodule

// File: tb/tb_round_controller.sv
// -----------------------------------------------------------------------------
// Testbench for round_controller.
//
// The driver applies one set of inputs per clock, shortly after the rising
// edge. For each cycle it pushes the outputs the DUT must be showing during
// that cycle (after any asynchronous reset just applied) into a scoreboard
// queue, then advances a behavioural game model by the rules of the game.
// A separate monitor pops one entry per falling edge and compares.
// -----------------------------------------------------------------------------
module tb_round_controller;

    localparam int ROUND_TIME   = 15;
    localparam int BREAK_TIME   = 5;
    localparam int DOUBLE_EVERY = 5;
    localparam int SCORE_W      = 16;

    localparam int P_IDLE  = 0;
    localparam int P_BREAK = 1;
    localparam int P_PLAY  = 2;
    localparam int P_OVER  = 3;

    logic               clk;
    logic               reset_n;
    logic               start;
    logic               tick_1hz;
    logic               check_valid;
    logic               is_correct;
    logic               new_prompt;
    logic [5:0]         count;
    logic [1:0]         phase;
    logic [7:0]         round_num;
    logic [SCORE_W-1:0] score;
    logic               game_over;
`ifdef ROUND_CONTROLLER_HIGH_SCORE_EN
    logic [SCORE_W-1:0] best_score;
`endif

    round_controller #(
        .ROUND_TIME  (ROUND_TIME),
        .BREAK_TIME  (BREAK_TIME),
        .DOUBLE_EVERY(DOUBLE_EVERY),
        .SCORE_W     (SCORE_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .tick_1hz   (tick_1hz),
        .check_valid(check_valid),
        .is_correct (is_correct),
        .new_prompt (new_prompt),
        .count      (count),
        .phase      (phase),
        .round_num  (round_num),
        .score      (score),
        .game_over  (game_over)
`ifdef ROUND_CONTROLLER_HIGH_SCORE_EN
        ,
        .best_score (best_score)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Behavioural game model
    // ---------------------------------------------------------------------
    typedef struct {
        int     ph;
        int     cnt;
        int     rn;
        longint sc;
        bit     np;
        bit     go;
        longint best;
    } exp_t;

    exp_t   sb_q[$];
    int     m_ph   = P_IDLE;
    int     m_cnt  = 0;
    int     m_rn   = 0;
    longint m_sc   = 0;
    bit     m_np   = 1'b0;
    longint m_best = 0;
    longint score_max = (longint'(1) << SCORE_W) - 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_reset();
        m_ph = P_IDLE; m_cnt = 0; m_rn = 0; m_sc = 0; m_np = 1'b0; m_best = 0;
    endtask

    task automatic model_end_game(input int final_cnt);
        m_ph  = P_OVER;
        m_cnt = final_cnt;
        if (m_sc > m_best) m_best = m_sc;
    endtask

    task automatic model_step(input bit st, input bit tk, input bit cv, input bit ic);
        int tier;
        longint pts;
        m_np = 1'b0;
        case (m_ph)
            P_IDLE, P_OVER: begin
                if (st) begin
                    m_ph = P_BREAK; m_cnt = BREAK_TIME; m_rn = 0; m_sc = 0;
                end
            end
            P_BREAK: begin
                if (tk) begin
                    if (m_cnt == 1) begin
                        m_ph = P_PLAY; m_cnt = ROUND_TIME; m_np = 1'b1;
                    end else begin
                        m_cnt--;
                    end
                end
            end
            default: begin // PLAY
                if (cv && ic) begin
                    tier = m_rn / DOUBLE_EVERY;
                    if (tier > 7) tier = 7;
                    pts  = longint'(2) << tier;
                    m_sc = (m_sc + pts > score_max) ? score_max : m_sc + pts;
                    m_rn = (m_rn == 255) ? 255 : m_rn + 1;
                    m_ph = P_BREAK; m_cnt = BREAK_TIME;
                end else if (cv) begin
                    model_end_game(m_cnt);
                end else if (tk) begin
                    if (m_cnt == 1) model_end_game(0);
                    else m_cnt--;
                end
            end
        endcase
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        e.ph = m_ph; e.cnt = m_cnt; e.rn = m_rn; e.sc = m_sc;
        e.np = m_np; e.go = (m_ph == P_OVER); e.best = m_best;
        return e;
    endfunction

    // ---------------------------------------------------------------------
    // Driver
    // ---------------------------------------------------------------------
    task automatic cyc(input bit rn, input bit st, input bit tk, input bit cv, input bit ic);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n     = rn;
        start       = st;
        tick_1hz    = tk;
        check_valid = cv;
        is_correct  = ic;
        if (!rn) model_reset();
        e = model_snapshot();
        sb_q.push_back(e);
        if (st || cv || !rn)
            $display("[%0t] txn rst_n=%0b start=%0b tick=%0b check=%0b correct=%0b | model phase=%0d count=%0d rounds=%0d score=%0d",
                     $time, rn, st, tk, cv, ic, e.ph, e.cnt, e.rn, e.sc);
        if (rn) model_step(st, tk, cv, ic);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 1, 0, 0);
    endtask

    // Break countdown into PLAY, a few play ticks, then a correct answer.
    task automatic pass_round(input int play_ticks);
        ticks(BREAK_TIME);
        idle(1);
        ticks(play_ticks);
        cyc(1, 0, 0, 1, 1);
        idle(1);
    endtask

    // ---------------------------------------------------------------------
    // Monitor
    // ---------------------------------------------------------------------
    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[%0t] FAIL %s: got %0d, expected %0d", $time, name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("phase",      longint'(phase),      e.ph);
            chk("count",      longint'(count),      e.cnt);
            chk("round_num",  longint'(round_num),  e.rn);
            chk("score",      longint'(score),      e.sc);
            chk("new_prompt", longint'(new_prompt), longint'(e.np));
            chk("game_over",  longint'(game_over),  longint'(e.go));
`ifdef ROUND_CONTROLLER_HIGH_SCORE_EN
            chk("best_score", longint'(best_score), e.best);
`endif
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        reset_n = 1'b0; start = 1'b0; tick_1hz = 1'b0;
        check_valid = 1'b0; is_correct = 1'b0;

        // Reset, then inputs other than start are ignored in IDLE.
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 1, 1, 1);
        cyc(1, 0, 1, 1, 0);

        // Start: break 5,4,3,2,1 (a check during break is ignored), into PLAY
        // at 15 with a single-cycle new_prompt.
        cyc(1, 1, 0, 0, 0);
        ticks(2);
        cyc(1, 0, 0, 1, 0);
        ticks(3);
        idle(2);

        // PLAY 15 -> 12, then a correct answer: round 1, score 2, BREAK at 5.
        ticks(3);
        cyc(1, 0, 0, 1, 1);
        idle(1);

        // Five more rounds: scores 4,6,8,10 then 14 after the doubling.
        // A start pulse during BREAK/PLAY must be ignored.
        pass_round(2);
        cyc(1, 1, 0, 0, 0);
        pass_round(0);
        pass_round(5);
        cyc(1, 1, 0, 0, 0);
        pass_round(1);
        pass_round(0);

        // Timeout: 15 ticks with no check -> GAMEOVER, count 0; then new game.
        ticks(BREAK_TIME);
        ticks(ROUND_TIME);
        idle(2);
        cyc(1, 1, 0, 0, 0);
        idle(1);

        // Last second: tick and correct check together -> round passes.
        ticks(BREAK_TIME);
        ticks(ROUND_TIME - 1);
        cyc(1, 0, 1, 1, 1);
        idle(1);

        // Reach score 8, enter PLAY, then asynchronous reset mid-PLAY.
        pass_round(1);
        pass_round(1);
        pass_round(1);
        ticks(BREAK_TIME);
        ticks(4);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);

        // Game ending at 8 on a wrong answer (count holds), then one ending
        // at 4 on timeout: best stays 8.
        cyc(1, 1, 0, 0, 0);
        for (int r = 0; r < 4; r++) pass_round(2);
        ticks(BREAK_TIME);
        ticks(6);
        cyc(1, 0, 0, 1, 0);
        idle(2);
        cyc(1, 1, 0, 0, 0);
        for (int r = 0; r < 2; r++) pass_round(0);
        ticks(BREAK_TIME);
        ticks(ROUND_TIME);
        idle(2);

        // Randomised play.
        for (int i = 0; i < 3000; i++) begin
            bit rn, st, tk, cv, ic;
            rn = ($urandom_range(0, 999) != 0);
            st = ($urandom_range(0, 39) == 0);
            tk = ($urandom_range(0, 2) == 0);
            cv = ($urandom_range(0, 9) == 0);
            ic = ($urandom_range(0, 7) != 0);
            cyc(rn, st, tk, cv, ic);
        end
        idle(2);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
